// File: rtl/branch_check_queue.sv
// In-order queue of fetch-time branch predictions, checked against execute-time
// resolution; flushes and redirects on a mispredict and keeps perf counters.
module branch_check_queue #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [31:0]      push_pc,
    input  logic             push_pred_taken,
    input  logic [31:0]      push_pred_target,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    input  logic             pop,
    input  logic [6:0]       exec_opcode,
    input  logic [31:0]      exec_pc,
    input  logic             exec_br_en,
    input  logic [31:0]      exec_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             pc_mismatch,
    output logic [31:0]      n_ctrl,
    output logic [31:0]      n_mispred
);
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           hd;
    logic [PTR_W-1:0] head, tail;
    logic             pop_v, push_v, is_ctrl, actual_taken, miss;
    logic [31:0]      actual_next, pred_next;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign pop_v  = pop & ~empty;
    assign push_v = push & (~full | pop_v);
    assign hd     = mem[head];

    always_comb begin
        is_ctrl      = (exec_opcode == OP_BR) || (exec_opcode == OP_JAL) || (exec_opcode == OP_JALR);
        actual_taken = (exec_opcode == OP_BR) ? exec_br_en : is_ctrl;
        actual_next  = actual_taken ? exec_target : exec_pc + 32'd4;
        pred_next    = hd.pred_taken ? hd.pred_target : hd.pc + 32'd4;
        miss         = pop_v && (actual_next != pred_next);
    end

    // Storage is never cleared; a push in a flush cycle is on the wrong path.
    always_ff @(posedge clk) begin
        if (!rst && push_v && !miss)
            mem[tail] <= '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            pc_mismatch <= 1'b0;
            n_ctrl      <= '0;
            n_mispred   <= '0;
        end else begin
            mispredict  <= miss;
            pc_mismatch <= pop_v && (hd.pc != exec_pc);
            if (miss)
                redirect_pc <= actual_next;
            if (pop_v && is_ctrl)
                n_ctrl <= n_ctrl + 32'd1;
            if (miss)
                n_mispred <= n_mispred + 32'd1;
            if (miss) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop_v)
                    head <= head + 1'b1;
                if (push_v)
                    tail <= tail + 1'b1;
                count <= count + (PTR_W+1)'(push_v) - (PTR_W+1)'(pop_v);
            end
        end
    end
endmodule
